// File: rtl/dff_sync_enable.sv
//------------------------------------------------------------------------------
// Module   : dff_sync_enable
// Purpose  : WIDTH-bit D register with a synchronous active-high reset and a
//            synchronous active-high load enable. Reset takes priority over
//            enable. With both inactive, the register holds its value.
//            All bits share one enable and one reset.
// Ports    : i_clk    - clock; state changes on the rising edge only
//            i_rst    - synchronous reset, active-high; loads RST_VAL
//            i_d      - data to capture (WIDTH bits)
//            i_enable - synchronous load enable, active-high
//            o_q      - registered output, driven directly by the flops
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns / 100ps
`default_nettype none

module dff_sync_enable #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_q
);

  // The declaration initialiser gives the power-up/configuration value. It
  // also keeps o_q defined in simulation before the first reset.
  logic [WIDTH-1:0] q_q = RST_VAL;
  logic [WIDTH-1:0] q_d;

  // Enable selects the new data. Otherwise the flop recirculates its own
  // value. This maps onto the clock-enable pin of the flop.
  always_comb begin
    q_d = q_q;
    if (i_enable) begin
      q_d = i_d;
    end
  end

  // Reset is sampled on the clock edge only. This maps onto the
  // synchronous-reset pin and overrides the enable path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_sync_enable.sv
//------------------------------------------------------------------------------
// Module   : tb_dff_sync_enable
// Purpose  : Self-checking bench for dff_sync_enable. It drives a 1-bit
//            default instance through directed scenarios and a time-based
//            free-running pattern. It drives an 8-bit instance with a non-zero
//            reset value using random stimulus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns / 100ps
`default_nettype none

module tb_dff_sync_enable;

  localparam logic [7:0] RST8 = 8'hA5;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d;
  logic       q;

  logic       rst8;
  logic       en8;
  logic [7:0] d8;
  logic [7:0] q8;

  int n_checks;
  int n_fail;

  dff_sync_enable dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_d      (d),
    .i_enable (en),
    .o_q      (q)
  );

  dff_sync_enable #(
    .WIDTH   (8),
    .RST_VAL (RST8)
  ) dut8 (
    .i_clk    (clk),
    .i_rst    (rst8),
    .i_d      (d8),
    .i_enable (en8),
    .o_q      (q8)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Before any edge, both instances must show their reset values.
  // Three edges with reset and enable low must not disturb the 1-bit output.
  task automatic test_reset();
    #1;
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL powerup_q: got %b expected 0", q);
    end
    n_checks++;
    if (q8 !== RST8) begin
      n_fail++;
      $display("FAIL powerup_q8: got %h expected %h", q8, RST8);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (q !== 1'b0) begin
        n_fail++;
        $display("FAIL powerup_hold[%0d]: got %b expected 0", i, q);
      end
    end
  endtask

  // With enable high, o_q follows i_d one edge later.
  // A change on i_d between edges must not reach o_q early.
  task automatic test_capture();
    @(negedge clk);
    en = 1'b1;
    d  = 1'b0;
    tick();
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_0: got %b expected 0", q);
    end
    @(negedge clk);
    d = 1'b1;
    #2;
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_midcycle: got %b expected 0", q);
    end
    tick();
    n_checks++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_1: got %b expected 1", q);
    end
  endtask

  // With enable low, o_q holds its value for 5 edges.
  // Re-asserting enable loads i_d at the next edge.
  task automatic test_enable_hold();
    @(negedge clk);
    en = 1'b0;
    d  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (q !== 1'b1) begin
        n_fail++;
        $display("FAIL enable_hold[%0d]: got %b expected 1", i, q);
      end
    end
    @(negedge clk);
    en = 1'b1;
    tick();
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_reassert: got %b expected 0", q);
    end
  endtask

  // Reset wins over enable, but only at the clock edge.
  // Raising reset must not change o_q before that edge.
  task automatic test_reset_priority();
    @(negedge clk);
    en = 1'b1;
    d  = 1'b1;
    tick();
    n_checks++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL rstprio_setup: got %b expected 1", q);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL rstprio_no_async: got %b expected 1", q);
    end
    tick();
    n_checks++;
    if (q !== 1'b0) begin
      n_fail++;
      $display("FAIL rstprio_edge: got %b expected 0", q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // A 5 ns reset pulse placed entirely between edges must have no effect.
  task automatic test_glitch_reset();
    @(negedge clk);
    en = 1'b1;
    d  = 1'b1;
    tick();
    @(negedge clk);
    en = 1'b0;
    d  = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #5;
    n_checks++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_during: got %b expected 1", q);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_after: got %b expected 1", q);
    end
  endtask

  // Time-based pattern: reset is high for 54 ns every 209 ns starting at
  // 155 ns, enable toggles every 63 ns, and i_d toggles every 250 ns.
  // The pattern is offset half a nanosecond from the clock grid so that no
  // input transition coincides with an edge. The reference applies
  // reset > enable > hold to the levels seen at each edge.
  task automatic test_free_running();
    logic exp;
    @(posedge clk);
    #0.5;
    rst = 1'b0;
    en  = 1'b0;
    d   = 1'b0;
    exp = q;
    fork
      begin
        #155;
        for (int k = 0; k < 9; k++) begin
          rst = 1'b1;
          #54;
          rst = 1'b0;
          #155;
        end
      end
      begin
        for (int k = 0; k < 31; k++) begin
          #63;
          en = ~en;
        end
      end
      begin
        for (int k = 0; k < 8; k++) begin
          #250;
          d = ~d;
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk);
          if (rst)     exp = 1'b0;
          else if (en) exp = d;
          #1;
          n_checks++;
          if (q !== exp) begin
            n_fail++;
            $display("FAIL freerun[%0d] t=%0t: got %b expected %b", i, $time, q, exp);
          end
        end
      end
    join
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  // Random cycle-by-cycle stimulus on the 8-bit instance with a non-zero
  // reset value. Back-to-back enables, holds, and resets are mixed.
  task automatic test_random_wide();
    logic [7:0] exp8;
    @(negedge clk);
    rst8 = 1'b1;
    en8  = 1'b0;
    d8   = 8'h00;
    tick();
    exp8 = RST8;
    n_checks++;
    if (q8 !== exp8) begin
      n_fail++;
      $display("FAIL rand_reset: got %h expected %h", q8, exp8);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rst8 = ($urandom_range(0, 7) == 0);
      en8  = ($urandom_range(0, 1) == 1);
      d8   = 8'($urandom);
      if (rst8)     exp8 = RST8;
      else if (en8) exp8 = d8;
      tick();
      n_checks++;
      if (q8 !== exp8) begin
        n_fail++;
        $display("FAIL rand[%0d]: rst=%b en=%b d=%h got %h expected %h",
                 i, rst8, en8, d8, q8, exp8);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    d        = 1'b1;
    rst8     = 1'b0;
    en8      = 1'b0;
    d8       = 8'h3C;

    test_reset();
    test_capture();
    test_enable_hold();
    test_reset_priority();
    test_glitch_reset();
    test_free_running();
    test_random_wide();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
